// File: rtl/bus_pkg.sv
// Shared bus types for the Z80-style memory bus: data/address words and the
// wait-state sequencer states used by every bus target.
package bus_pkg;

  localparam int BUS_DATA_WIDTH = 8;
  localparam int BUS_ADDR_WIDTH = 16;
  localparam int BUS_WAIT_CNT_W = 4;

  typedef logic [BUS_DATA_WIDTH-1:0] bus_data_t;
  typedef logic [BUS_ADDR_WIDTH-1:0] bus_addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } bus_mem_state_e;

endpackage

// File: rtl/bus_wait_gen.sv
// Wait-state sequencer: pulls buswait_n low for exactly WAIT_STATES cycles per
// request and flags the completion cycle; dropping req abandons the access.
module bus_wait_gen
  import bus_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  output logic buswait_n,
  output logic done
);

  localparam logic [BUS_WAIT_CNT_W-1:0] WS_C    = BUS_WAIT_CNT_W'(WAIT_STATES);
  localparam logic [BUS_WAIT_CNT_W-1:0] WS_LOAD =
    (WAIT_STATES > 0) ? BUS_WAIT_CNT_W'(WAIT_STATES - 1) : 4'd0;

  bus_mem_state_e              state_q, state_d;
  logic [BUS_WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                        buswait_s;

  // Next-state and wait strobe; the first wait cycle is the IDLE cycle itself.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buswait_s = 1'b1;
    case (state_q)
      IDLE: begin
        if (req && (WS_C != 4'd0)) begin
          buswait_s = 1'b0;
          state_d   = WAIT;
          cnt_d     = WS_LOAD;
        end else begin
          buswait_s = 1'b1;
        end
      end
      WAIT: begin
        if (!req) begin
          buswait_s = 1'b1;
          state_d   = IDLE;
          cnt_d     = 4'd0;
        end else if (cnt_q == 4'd0) begin
          buswait_s = 1'b1;
          state_d   = IDLE;
        end else begin
          buswait_s = 1'b0;
          cnt_d     = cnt_q - 4'd1;
        end
      end
      default: begin
        buswait_s = 1'b1;
        state_d   = IDLE;
        cnt_d     = 4'd0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign buswait_n = buswait_s;
  assign done      = req && buswait_s;

endmodule

// File: rtl/bus_mem_slave.sv
// RAM target on the shared memory bus with programmable wait states.
// Define BUS_MEM_ROM_EN to write-protect the first ROM_DEPTH words (sticky wp_err).
module bus_mem_slave
  import bus_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'h0000,
  parameter int                    DEPTH       = 256,
  parameter int                    WAIT_STATES = 0,
  parameter int                    ROM_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  iorq_n,
  input  logic                  mreq_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd_n,
  input  logic                  wr_n,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  buswait_n,
  output logic                  wp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  // One extra bit so the window end never wraps.
  localparam logic [ADDR_WIDTH:0] WIN_END = {1'b0, BASE_ADDR} + (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]      idx_s;
  logic                  in_win_s, sel_s, rd_acc_s, wr_acc_s, req_s, done_s;
  logic                  mem_we_s, wp_err_q, wp_err_d;

  // Bus cycle decode; reset_n gates the request so a reset aborts at once.
  always_comb begin
    in_win_s = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < WIN_END);
    sel_s    = (reset_n == 1'b1) && (mreq_n == 1'b0) && (iorq_n == 1'b1) && in_win_s;
    rd_acc_s = sel_s && (rd_n == 1'b0) && (wr_n == 1'b1);
    wr_acc_s = sel_s && (wr_n == 1'b0) && (rd_n == 1'b1);
    req_s    = rd_acc_s || wr_acc_s;
    idx_s    = IDX_W'(addr - BASE_ADDR);
  end

  bus_wait_gen #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_s),
    .buswait_n (buswait_n),
    .done      (done_s)
  );

`ifdef BUS_MEM_ROM_EN
  logic rom_hit_s;

  // Writes into the protected region are dropped and latched as a violation.
  always_comb begin
    rom_hit_s = (addr - BASE_ADDR) < ADDR_WIDTH'(ROM_DEPTH);
    if (done_s && wr_acc_s && rom_hit_s) begin
      mem_we_s = 1'b0;
      wp_err_d = 1'b1;
    end else begin
      mem_we_s = done_s && wr_acc_s;
      wp_err_d = wp_err_q;
    end
  end
`else
  // Whole window writable; no violations possible.
  always_comb begin
    mem_we_s = done_s && wr_acc_s;
    wp_err_d = 1'b0;
  end
`endif

  // Sticky write-protect flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_err_q <= 1'b0;
    end else begin
      wp_err_q <= wp_err_d;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= data;
    end
  end

  assign data   = rd_acc_s ? mem_q[idx_s] : {DATA_WIDTH{1'bz}};
  assign wp_err = wp_err_q;

endmodule
